// File: rtl/fpro_bus_arbiter_pkg.sv
// Shared types for the two-master FPro bus arbiter.
// Bus widths, FSM state encoding and the latched command record.
package fp_arb_pkg;

    localparam int FP_ADDR_W = 21;
    localparam int FP_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                 video;
        logic                 wr;
        logic [FP_ADDR_W-1:0] addr;
        logic [FP_DATA_W-1:0] wr_data;
    } fp_cmd_t;

endpackage

// File: rtl/fpro_bus_arbiter_if.sv
// Master-side handshakes and FPro bus signals of the arbiter.
// The slave modport is the arbiter's view; master is the masters'/bus side.
interface fpro_bus_arbiter_if
    import fp_arb_pkg::*;
#(
    parameter int ADDR_W = FP_ADDR_W,
    parameter int DATA_W = FP_DATA_W
);
    logic              m0_req;
    logic              m0_video;
    logic              m0_wr;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wr_data;
    logic              m0_lock;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rd_data;

    logic              m1_req;
    logic              m1_video;
    logic              m1_wr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wr_data;
    logic              m1_lock;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rd_data;

    logic              fp_mmio_cs;
    logic              fp_video_cs;
    logic              fp_wr;
    logic              fp_rd;
    logic [ADDR_W-1:0] fp_addr;
    logic [DATA_W-1:0] fp_wr_data;
    logic [DATA_W-1:0] fp_rd_data;
    logic [1:0]        grant;

    modport slave (
        input  m0_req, m0_video, m0_wr, m0_addr, m0_wr_data, m0_lock,
        input  m1_req, m1_video, m1_wr, m1_addr, m1_wr_data, m1_lock,
        input  fp_rd_data,
        output m0_ack, m0_rd_data, m1_ack, m1_rd_data,
        output fp_mmio_cs, fp_video_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
        output grant
    );

    modport master (
        output m0_req, m0_video, m0_wr, m0_addr, m0_wr_data, m0_lock,
        output m1_req, m1_video, m1_wr, m1_addr, m1_wr_data, m1_lock,
        output fp_rd_data,
        input  m0_ack, m0_rd_data, m1_ack, m1_rd_data,
        input  fp_mmio_cs, fp_video_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
        input  grant
    );

endinterface

// File: rtl/fpro_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker; pick is combinational, `last` updates on take.
// With FP_ARB_LOCK_EN the owner can hold the bus for up to LOCK_MAX extra grants.
module fp_rr_arb2 #(
    parameter int LOCK_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
`ifdef FP_ARB_LOCK_EN
    input  logic [1:0] lock,
    input  logic       lock_sample,
`endif
    output logic [1:0] pick
);

    // last_q = 1 means m1 owned the bus most recently
    logic       last_q;
    logic [1:0] rr_pick;

    always_comb begin
        rr_pick = req;
        if (req == 2'b11) begin
            rr_pick = last_q ? 2'b01 : 2'b10;
        end
    end

`ifdef FP_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic             hold_q;
    logic [CNT_W-1:0] cnt_q;
    logic             owner_req;
    logic             other_req;
    logic             locked;

    assign owner_req = last_q ? req[1] : req[0];
    assign other_req = last_q ? req[0] : req[1];
    // The cap only bites when the other master is actually waiting
    assign locked    = hold_q && owner_req &&
                       !((cnt_q == CNT_W'(LOCK_MAX)) && other_req);
    assign pick      = locked ? (last_q ? 2'b10 : 2'b01) : rr_pick;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
            hold_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (lock_sample) begin
                hold_q <= last_q ? lock[1] : lock[0];
            end
            if (take) begin
                last_q <= pick[1];
                if (!locked) begin
                    cnt_q <= '0;
                end else if (cnt_q != CNT_W'(LOCK_MAX)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end
`else
    assign pick = rr_pick;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (take) begin
            last_q <= pick[1];
        end
    end
`endif

endmodule

// File: rtl/fpro_bus_arbiter.sv
// Shares the FPro bus between two masters, one strobe cycle per transaction.
// Optional ownership locking is compiled in with FP_ARB_LOCK_EN.
//
// state | meaning
// IDLE  | waiting for a request; on grant latch the command
// XFER  | strobe cycle: fp_* driven from the command, read data captured
// DONE  | owner's ack pulse, bus quiet
module fpro_bus_arbiter
    import fp_arb_pkg::*;
#(
    parameter int ADDR_W   = FP_ADDR_W,
    parameter int DATA_W   = FP_DATA_W,
    parameter int LOCK_MAX = 16
) (
    input  logic                clk,
    input  logic                reset,
    fpro_bus_arbiter_if.slave   bus
);

    arb_state_t        state;
    fp_cmd_t           cmd_q;
    fp_cmd_t           sel_cmd;
    logic [1:0]        pick;
    logic              take;
    logic              xfer;
    logic [1:0]        grant_q;
    logic              m0_ack_q;
    logic              m1_ack_q;
    logic [DATA_W-1:0] m0_rd_q;
    logic [DATA_W-1:0] m1_rd_q;

    assign take = (state == IDLE) && (pick != 2'b00);
    assign xfer = (state == XFER);

    fp_rr_arb2 #(
        .LOCK_MAX    (LOCK_MAX)
    ) u_rr_arb2 (
        .clk         (clk),
        .reset       (reset),
        .req         ({bus.m1_req, bus.m0_req}),
        .take        (take),
`ifdef FP_ARB_LOCK_EN
        .lock        ({bus.m1_lock, bus.m0_lock}),
        .lock_sample (state == DONE),
`endif
        .pick        (pick)
    );

`ifndef FP_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = bus.m0_lock ^ bus.m1_lock;
`endif

    always_comb begin
        sel_cmd = '0;
        if (pick[1]) begin
            sel_cmd.video   = bus.m1_video;
            sel_cmd.wr      = bus.m1_wr;
            sel_cmd.addr    = bus.m1_addr;
            sel_cmd.wr_data = bus.m1_wr_data;
        end else begin
            sel_cmd.video   = bus.m0_video;
            sel_cmd.wr      = bus.m0_wr;
            sel_cmd.addr    = bus.m0_addr;
            sel_cmd.wr_data = bus.m0_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cmd_q    <= '0;
            grant_q  <= 2'b00;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            m0_rd_q  <= '0;
            m1_rd_q  <= '0;
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        cmd_q   <= sel_cmd;
                        grant_q <= pick;
                        state   <= XFER;
                    end
                end
                XFER: begin
                    if (!cmd_q.wr) begin
                        if (grant_q[1]) m1_rd_q <= bus.fp_rd_data;
                        else            m0_rd_q <= bus.fp_rd_data;
                    end
                    // Clearing the command keeps addr/data buses quiet outside XFER
                    cmd_q    <= '0;
                    m0_ack_q <= grant_q[0];
                    m1_ack_q <= grant_q[1];
                    state    <= DONE;
                end
                DONE: begin
                    grant_q <= 2'b00;
                    state   <= IDLE;
                end
                default: begin
                    grant_q <= 2'b00;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.fp_mmio_cs  = xfer & ~cmd_q.video;
    assign bus.fp_video_cs = xfer &  cmd_q.video;
    assign bus.fp_wr       = xfer &  cmd_q.wr;
    assign bus.fp_rd       = xfer & ~cmd_q.wr;
    assign bus.fp_addr     = ADDR_W'(cmd_q.addr);
    assign bus.fp_wr_data  = DATA_W'(cmd_q.wr_data);
    assign bus.grant       = grant_q;
    assign bus.m0_ack      = m0_ack_q;
    assign bus.m1_ack      = m1_ack_q;
    assign bus.m0_rd_data  = m0_rd_q;
    assign bus.m1_rd_data  = m1_rd_q;

endmodule
